// File: rtl/axis_deadlock_monitor_multi.sv
// AXI-Stream deadlock monitor: qualifies per-channel block indications after
// THRESH consecutive blocked cycles, encodes per-channel info, captures the
// first offending channel and counts how long the aggregate block lasts.
module axis_deadlock_monitor_multi #(
    parameter int NUM_CH   = 4,
    parameter int NUM_INST = 1,
    parameter int INFO_W   = 4,
    parameter int THRESH   = 1,
    parameter int CNT_W    = 16,
    parameter int STICKY   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        axis_block_sigs,
    input  logic [NUM_INST-1:0]      inst_idle_sigs,
    input  logic [NUM_INST-1:0]      inst_block_sigs,
    input  logic                     clear,
    output logic [NUM_CH*INFO_W-1:0] axis_block_info,
    output logic                     block,
    output logic [7:0]               first_ch,
    output logic                     first_valid,
    output logic [CNT_W-1:0]         block_cycles
);

    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic              all_idle;
    logic [NUM_CH-1:0] flag_q;
    logic [NUM_CH-1:0] flag_d;
    logic [NUM_CH-1:0] flag_rise;

    logic [7:0]        first_ch_q, first_ch_d;
    logic              first_valid_q, first_valid_d;
    logic [CNT_W-1:0]  block_cycles_q, block_cycles_d;

    // Sub-instance block indications are reserved and intentionally ignored.
    logic unused_inst_block;
    assign unused_inst_block = ^inst_block_sigs;

    assign all_idle = &inst_idle_sigs;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [INFO_W-1:0] INFO_CODE = ~INFO_W'(1 << (gi % INFO_W));

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             ch_flag_q, ch_flag_d;

            // Persistence counter and qualified flag, in priority order clear > idle > block.
            always_comb begin
                cnt_d     = cnt_q;
                ch_flag_d = ch_flag_q;
                if (clear) begin
                    cnt_d     = '0;
                    ch_flag_d = 1'b0;
                end else if (all_idle) begin
                    cnt_d = '0;
                    if (STICKY == 0) ch_flag_d = 1'b0;
                end else if (axis_block_sigs[gi]) begin
                    if (cnt_q < THRESH_M1) cnt_d = cnt_q + 1'b1;
                    else                   ch_flag_d = 1'b1;
                end else begin
                    cnt_d = '0;
                    if (STICKY == 0) ch_flag_d = 1'b0;
                end
            end

            // Per-channel state register.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q     <= '0;
                    ch_flag_q <= 1'b0;
                end else begin
                    cnt_q     <= cnt_d;
                    ch_flag_q <= ch_flag_d;
                end
            end

            assign flag_q[gi] = ch_flag_q;
            assign flag_d[gi] = ch_flag_d;
            assign axis_block_info[gi*INFO_W +: INFO_W] = ch_flag_q ? INFO_CODE : '0;
        end
    endgenerate

    assign flag_rise = flag_d & ~flag_q;
    assign block     = |flag_q;

    // First-offender capture and saturating block-duration counter.
    always_comb begin
        first_ch_d     = first_ch_q;
        first_valid_d  = first_valid_q;
        block_cycles_d = block_cycles_q;
        if (clear) begin
            first_ch_d     = '0;
            first_valid_d  = 1'b0;
            block_cycles_d = '0;
        end else begin
            if (!first_valid_q && (|flag_rise)) begin
                first_valid_d = 1'b1;
                // Scan downwards so the lowest rising index wins.
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (flag_rise[i]) first_ch_d = 8'(i);
                end
            end
            if (block && (block_cycles_q != CNT_MAX)) begin
                block_cycles_d = block_cycles_q + 1'b1;
            end
        end
    end

    // Capture/counter state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_ch_q     <= '0;
            first_valid_q  <= 1'b0;
            block_cycles_q <= '0;
        end else begin
            first_ch_q     <= first_ch_d;
            first_valid_q  <= first_valid_d;
            block_cycles_q <= block_cycles_d;
        end
    end

    assign first_ch     = first_ch_q;
    assign first_valid  = first_valid_q;
    assign block_cycles = block_cycles_q;

endmodule

// File: tb/tb_axis_deadlock_monitor_multi.sv
// Directed bench for axis_deadlock_monitor_multi: several instances with
// different THRESH/STICKY/CNT_W settings, each driven by its own inputs.
module tb_axis_deadlock_monitor_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // A: THRESH=1, non-sticky
    logic [3:0]  blk_a, info_dummy_a;
    logic        clr_a, idle_a, iblk_a;
    logic [15:0] info_a;
    logic        block_a, fv_a;
    logic [7:0]  fch_a;
    logic [15:0] bc_a;
    // B: THRESH=4
    logic [3:0]  blk_b;
    logic        clr_b, idle_b, iblk_b;
    logic [15:0] info_b;
    logic        block_b, fv_b;
    logic [7:0]  fch_b;
    logic [15:0] bc_b;
    // C: THRESH=2, sticky
    logic [3:0]  blk_c;
    logic        clr_c, idle_c, iblk_c;
    logic [15:0] info_c;
    logic        block_c, fv_c;
    logic [7:0]  fch_c;
    logic [15:0] bc_c;
    // D: THRESH=3, two sub-instances
    logic [3:0]  blk_d;
    logic        clr_d;
    logic [1:0]  idle_d, iblk_d;
    logic [15:0] info_d;
    logic        block_d, fv_d;
    logic [7:0]  fch_d;
    logic [15:0] bc_d;
    // E: CNT_W=4, THRESH=1
    logic [3:0]  blk_e;
    logic        clr_e, idle_e, iblk_e;
    logic [15:0] info_e;
    logic        block_e, fv_e;
    logic [7:0]  fch_e;
    logic [3:0]  bc_e;

    axis_deadlock_monitor_multi #(.THRESH(1), .STICKY(0)) u_a (
        .clock(clk), .reset(rst), .axis_block_sigs(blk_a), .inst_idle_sigs(idle_a),
        .inst_block_sigs(iblk_a), .clear(clr_a), .axis_block_info(info_a), .block(block_a),
        .first_ch(fch_a), .first_valid(fv_a), .block_cycles(bc_a));

    axis_deadlock_monitor_multi #(.THRESH(4), .STICKY(0)) u_b (
        .clock(clk), .reset(rst), .axis_block_sigs(blk_b), .inst_idle_sigs(idle_b),
        .inst_block_sigs(iblk_b), .clear(clr_b), .axis_block_info(info_b), .block(block_b),
        .first_ch(fch_b), .first_valid(fv_b), .block_cycles(bc_b));

    axis_deadlock_monitor_multi #(.THRESH(2), .STICKY(1)) u_c (
        .clock(clk), .reset(rst), .axis_block_sigs(blk_c), .inst_idle_sigs(idle_c),
        .inst_block_sigs(iblk_c), .clear(clr_c), .axis_block_info(info_c), .block(block_c),
        .first_ch(fch_c), .first_valid(fv_c), .block_cycles(bc_c));

    axis_deadlock_monitor_multi #(.THRESH(3), .NUM_INST(2)) u_d (
        .clock(clk), .reset(rst), .axis_block_sigs(blk_d), .inst_idle_sigs(idle_d),
        .inst_block_sigs(iblk_d), .clear(clr_d), .axis_block_info(info_d), .block(block_d),
        .first_ch(fch_d), .first_valid(fv_d), .block_cycles(bc_d));

    axis_deadlock_monitor_multi #(.THRESH(1), .CNT_W(4)) u_e (
        .clock(clk), .reset(rst), .axis_block_sigs(blk_e), .inst_idle_sigs(idle_e),
        .inst_block_sigs(iblk_e), .clear(clr_e), .axis_block_info(info_e), .block(block_e),
        .first_ch(fch_e), .first_valid(fv_e), .block_cycles(bc_e));

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-24s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        info_dummy_a = '0;
        blk_a = '0; clr_a = 0; idle_a = 0; iblk_a = 0;
        blk_b = '0; clr_b = 0; idle_b = 0; iblk_b = 0;
        blk_c = '0; clr_c = 0; idle_c = 0; iblk_c = 0;
        blk_d = '0; clr_d = 0; idle_d = '0; iblk_d = '0;
        blk_e = '0; clr_e = 0; idle_e = 0; iblk_e = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_block_a", {31'd0, block_a}, 32'd0);
        check("rst_info_a", {16'd0, info_a}, 32'd0);
        check("rst_first_valid_a", {31'd0, fv_a}, 32'd0);
        check("rst_block_cycles_a", {16'd0, bc_a}, 32'd0);

        // A: single-cycle pulse on ch2
        blk_a = 4'b0100; tick();
        blk_a = 4'b0000;
        check("a_pulse_block", {31'd0, block_a}, 32'd1);
        check("a_pulse_info", {16'd0, info_a}, 32'h0B00);
        check("a_pulse_first_ch", {24'd0, fch_a}, 32'd2);
        check("a_pulse_first_valid", {31'd0, fv_a}, 32'd1);
        tick();
        check("a_drop_block", {31'd0, block_a}, 32'd0);
        check("a_drop_info", {16'd0, info_a}, 32'd0);
        check("a_drop_first_valid", {31'd0, fv_a}, 32'd1);
        check("a_drop_block_cycles", {16'd0, bc_a}, 32'd1);

        // A: clear then simultaneous ch0 and ch3
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        check("a_clr_first_valid", {31'd0, fv_a}, 32'd0);
        blk_a = 4'b1001; tick(); blk_a = 4'b0000;
        check("a_multi_info", {16'd0, info_a}, 32'h700E);
        check("a_multi_first_ch", {24'd0, fch_a}, 32'd0);
        check("a_multi_first_valid", {31'd0, fv_a}, 32'd1);

        // B: three-cycle run on ch1 must not qualify
        blk_b = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_short_block", {31'd0, block_b}, 32'd0);
        end
        blk_b = 4'b0000; tick();
        check("b_short_drop_block", {31'd0, block_b}, 32'd0);
        // B: four-cycle run qualifies on the fourth edge
        blk_b = 4'b0010;
        tick(); tick(); tick();
        check("b_run3_block", {31'd0, block_b}, 32'd0);
        tick();
        check("b_run4_block", {31'd0, block_b}, 32'd1);
        check("b_run4_info", {16'd0, info_b}, 32'h00D0);
        check("b_run4_cycles", {16'd0, bc_b}, 32'd0);
        tick();
        check("b_run5_cycles", {16'd0, bc_b}, 32'd1);
        tick();
        check("b_run6_cycles", {16'd0, bc_b}, 32'd2);
        blk_b = 4'b0000; tick();
        check("b_release_block", {31'd0, block_b}, 32'd0);

        // C: sticky flag survives input drop
        blk_c = 4'b0010; tick();
        check("c_run1_block", {31'd0, block_c}, 32'd0);
        tick();
        check("c_run2_block", {31'd0, block_c}, 32'd1);
        blk_c = 4'b0000; tick(); tick();
        check("c_sticky_block", {31'd0, block_c}, 32'd1);
        check("c_sticky_info", {16'd0, info_c}, 32'h00D0);
        check("c_sticky_cycles", {16'd0, bc_c}, 32'd2);
        clr_c = 1'b1; tick(); clr_c = 1'b0;
        check("c_clr_block", {31'd0, block_c}, 32'd0);
        check("c_clr_info", {16'd0, info_c}, 32'd0);
        check("c_clr_first_valid", {31'd0, fv_c}, 32'd0);
        check("c_clr_cycles", {16'd0, bc_c}, 32'd0);
        // C: clear on same edge as active block restarts counting
        blk_c = 4'b0010; clr_c = 1'b1; tick(); clr_c = 1'b0;
        tick();
        check("c_clrblk_run1_block", {31'd0, block_c}, 32'd0);
        tick();
        check("c_clrblk_run2_block", {31'd0, block_c}, 32'd1);
        check("c_clrblk_first_ch", {24'd0, fch_c}, 32'd1);
        blk_c = 4'b0000;

        // D: all sub-instances idle suppresses counting
        idle_d = 2'b11; blk_d = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("d_idle_block", {31'd0, block_d}, 32'd0);
        end
        // Only one sub-instance idle: counting proceeds
        idle_d = 2'b01;
        tick();
        check("d_run1_block", {31'd0, block_d}, 32'd0);
        tick();
        check("d_run2_block", {31'd0, block_d}, 32'd0);
        tick();
        check("d_run3_block", {31'd0, block_d}, 32'd1);
        check("d_run3_info", {16'd0, info_d}, 32'h000E);
        idle_d = 2'b11; tick();
        check("d_reidle_block", {31'd0, block_d}, 32'd0);
        blk_d = 4'b0000;

        // E: saturating block_cycles with CNT_W=4
        blk_e = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1)  check("e_k1_cycles", {28'd0, bc_e}, 32'd0);
            if (k == 10) check("e_k10_cycles", {28'd0, bc_e}, 32'd9);
            if (k == 16) check("e_k16_cycles", {28'd0, bc_e}, 32'd15);
            if (k == 20) check("e_k20_cycles", {28'd0, bc_e}, 32'd15);
        end
        check("e_sat_block", {31'd0, block_e}, 32'd1);
        rst = 1'b1; tick();
        check("e_rst_block", {31'd0, block_e}, 32'd0);
        check("e_rst_info", {16'd0, info_e}, 32'd0);
        check("e_rst_first_ch", {24'd0, fch_e}, 32'd0);
        check("e_rst_first_valid", {31'd0, fv_e}, 32'd0);
        check("e_rst_cycles", {28'd0, bc_e}, 32'd0);
        rst = 1'b0; blk_e = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_deadlock_monitor_multi.md
Name: axis_deadlock_monitor_multi

Overview:
Parametrised AXI-Stream deadlock monitor for HLS co-simulation benches. It watches NUM_CH per-channel AXIS block indications. A channel is flagged only after its block persists for THRESH consecutive cycles. Optional sticky latching is provided, along with first-offender capture and a saturating block-duration counter. It sits beside the DUT instance in the sim top level and feeds the deadlock reporter.

Parameters:
NUM_CH, 4, number of monitored AXIS channels (1..256)
NUM_INST, 1, number of sub-instance idle/block signals
INFO_W, 4, width of each per-channel info field
THRESH, 1, consecutive blocked cycles required to qualify a channel (1..2^CNT_W-1)
CNT_W, 16, width of the persistence counters and the block_cycles counter
STICKY, 0, 1 = qualified flags hold until clear or reset

Ports:
clock  in  1  sole clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
axis_block_sigs  in  NUM_CH  per-channel AXIS blocked indication
inst_idle_sigs  in  NUM_INST  sub-instance idle indications
inst_block_sigs  in  NUM_INST  sub-instance block indications; reserved, no effect in this revision
clear  in  1  synchronous clear of flags, capture and counters
axis_block_info  out  NUM_CH*INFO_W  per-channel encoded block info; field i occupies bits [i*INFO_W +: INFO_W]
block  out  1  OR of all qualified channel flags
first_ch  out  8  index of the first channel to qualify
first_valid  out  1  first_ch holds a valid value
block_cycles  out  CNT_W  number of cycles block has been high, saturating

Behaviour:
- One clock, synchronous active-high reset. Reset has priority over everything.
- Reset values: all outputs 0; all per-channel counters cnt[i] = 0; all flags flag[i] = 0.
- all_idle = AND of inst_idle_sigs.

Per-channel logic, with priority in this order:
1. reset.
2. clear: cnt[i] <= 0, flag[i] <= 0.
3. all_idle = 1: cnt[i] <= 0. flag[i] <= 0 when STICKY = 0; flag[i] holds when STICKY = 1.
4. axis_block_sigs[i] = 1:
   - If cnt[i] < THRESH-1: cnt[i] <= cnt[i]+1.
   - If cnt[i] == THRESH-1: flag[i] <= 1 and cnt[i] holds (saturates).
5. axis_block_sigs[i] = 0: cnt[i] <= 0. flag[i] <= 0 when STICKY = 0; flag[i] holds when STICKY = 1.

Timing:
- flag[i] rises on the edge that samples the THRESH-th consecutive high of axis_block_sigs[i].
- With THRESH = 1, the latency from input to output is one cycle.

Output encoding:
- block = OR of flag[]; it is a registered-state function with no combinational path from the inputs.
- Field i of axis_block_info = flag[i] ? ~(1 << (i mod INFO_W)) truncated to INFO_W bits : 0.

First-offender capture:
- While first_valid = 0, any edge on which some flag rises latches first_ch <= the lowest index among the rising flags, and sets first_valid <= 1.
- first_ch and first_valid then hold, even in non-sticky mode, until clear or reset.

block_cycles:
- Increments on each edge where block = 1, saturating at 2^CNT_W-1.
- Cleared by clear or reset; never decrements otherwise.

clear:
- clear together with an active block input on the same edge: clear wins, and counting restarts on the next edge.
- clear clears first_ch to 0 and first_valid to 0.

Boundary cases:
- A channel dropping at cnt = THRESH-1 must not qualify.
- Multiple channels may qualify on the same cycle; each field is independent.

Test Plan:
- THRESH=1, STICKY=0; axis_block_sigs=4'b0100 for one cycle -> next cycle block=1, axis_block_info=16'h0B00, first_ch=2, first_valid=1; the cycle after that block=0 and info=0, while first_valid stays 1.
- THRESH=4; ch1 high for 3 cycles then low -> block never asserts. Then ch1 high for 4 cycles -> block=1 after the 4th edge, info=16'h00D0, block_cycles counts 1,2,... while ch1 stays high.
- THRESH=1; ch0 and ch3 asserted in the same cycle -> info=16'h700E, first_ch=0.
- STICKY=1, THRESH=2; ch1 high for 2 cycles then low -> block stays 1 with info=16'h00D0. Pulse clear -> next cycle block=0, info=0, first_valid=0, block_cycles=0.
- inst_idle_sigs=1 while ch0 is held high -> block stays 0 and cnt stays 0. Deassert idle with THRESH=3 -> block rises on the 3rd edge after.
- CNT_W=4, THRESH=1; ch2 held high for 20 cycles -> block_cycles saturates at 15. Assert reset mid-block -> the next cycle shows all outputs 0.
